// File: rtl/noc_pkg.sv
// Shared port indices, select/index types and small helpers for the 5-port router.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef logic [2:0] port_idx_t;
  typedef logic [NUM_PORTS-1:0] sel_t;

  localparam port_idx_t P_IDX = 3'd0;
  localparam port_idx_t E_IDX = 3'd1;
  localparam port_idx_t S_IDX = 3'd2;
  localparam port_idx_t W_IDX = 3'd3;
  localparam port_idx_t N_IDX = 3'd4;

  function automatic port_idx_t next_idx(input port_idx_t p);
    return (p >= port_idx_t'(NUM_PORTS - 1)) ? '0 : p + 3'd1;
  endfunction

  function automatic port_idx_t onehot_to_idx(input sel_t s);
    port_idx_t r;
    r = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (s[k]) r = port_idx_t'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational 5-way round-robin pick: first request at or after ptr, wrapping modulo 5.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output sel_t                 gnt
);

  port_idx_t idx;
  logic      found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = (ptr > N_IDX) ? P_IDX : ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-cycle wormhole switch allocator for the 5-port crossbar, registered outputs.
// Optional downstream credit gating is compiled in with `define ALLOC_CREDIT_EN.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int CREDIT_DEPTH = 4,
  parameter int RR_INIT      = 0
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   in_req,
  input  logic [3*NUM_PORTS-1:0] in_port,
  input  logic [NUM_PORTS-1:0]   in_tail,
  output logic [NUM_PORTS-1:0]   in_gnt,
  output sel_t                   proc_sel_code,
  output sel_t                   east_sel_code,
  output sel_t                   south_sel_code,
  output sel_t                   west_sel_code,
  output sel_t                   north_sel_code,
  output logic [NUM_PORTS-1:0]   out_busy
`ifdef ALLOC_CREDIT_EN
  ,
  input  logic [NUM_PORTS-1:0]   credit_ret
`endif
);

  // Handshake: in_req is a level held with in_port/in_tail until the input sees
  // in_gnt; in_gnt is a one-cycle pop strobe, registered one edge after sampling.

  port_idx_t            dest     [NUM_PORTS];
  port_idx_t            hold_out [NUM_PORTS];
  logic [NUM_PORTS-1:0] legal;
  logic [NUM_PORTS-1:0] hold_any;
  logic [NUM_PORTS-1:0] cand     [NUM_PORTS];
  sel_t                 arb_gnt  [NUM_PORTS];
  sel_t                 gnt_oh   [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_gnt_any;
  logic [NUM_PORTS-1:0] in_gnt_n;
  logic [NUM_PORTS-1:0] credit_ok;
  port_idx_t            widx;

  logic [NUM_PORTS-1:0] lock_q, lock_n;
  port_idx_t            owner_q [NUM_PORTS];
  port_idx_t            owner_n [NUM_PORTS];
  port_idx_t            ptr_q   [NUM_PORTS];
  port_idx_t            ptr_n   [NUM_PORTS];
  sel_t                 sel_q   [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_q;

  // An input that owns a locked output is only a candidate for that output.
  always_comb begin
    legal    = '0;
    hold_any = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest[i]     = in_port[3*i +: 3];
      hold_out[i] = '0;
      legal[i]    = in_req[i] && (dest[i] <= N_IDX) && (dest[i] != port_idx_t'(i));
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_q[o]) begin
        hold_any[owner_q[o]] = 1'b1;
        hold_out[owner_q[o]] = port_idx_t'(o);
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = legal[i] && (dest[i] == port_idx_t'(o))
                     && (!hold_any[i] || (hold_out[i] == port_idx_t'(o)));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .req (cand[o]),
      .ptr (ptr_q[o]),
      .gnt (arb_gnt[o])
    );
  end

  always_comb begin
    lock_n      = lock_q;
    out_gnt_any = '0;
    in_gnt_n    = '0;
    widx        = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      owner_n[o] = owner_q[o];
      ptr_n[o]   = ptr_q[o];
      gnt_oh[o]  = '0;
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_q[o]) begin
        if (credit_ok[o] && cand[o][owner_q[o]]) begin
          gnt_oh[o][owner_q[o]] = 1'b1;
          if (in_tail[owner_q[o]]) lock_n[o] = 1'b0;
        end
      end else if (credit_ok[o] && (|cand[o])) begin
        widx      = onehot_to_idx(arb_gnt[o]);
        gnt_oh[o] = arb_gnt[o];
        ptr_n[o]  = next_idx(widx);
        if (!in_tail[widx]) begin
          lock_n[o]  = 1'b1;
          owner_n[o] = widx;
        end
      end
      out_gnt_any[o] = |gnt_oh[o];
      in_gnt_n       = in_gnt_n | gnt_oh[o];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
      gnt_q  <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= port_idx_t'(RR_INIT);
        sel_q[o]   <= '0;
      end
    end else begin
      lock_q <= lock_n;
      gnt_q  <= in_gnt_n;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner_q[o] <= owner_n[o];
        ptr_q[o]   <= ptr_n[o];
        sel_q[o]   <= gnt_oh[o];
      end
    end
  end

`ifdef ALLOC_CREDIT_EN
  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  logic [CW-1:0] credit_q [NUM_PORTS];

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      credit_ok[o] = (credit_q[o] != '0);
    end
  end

  // A return and a grant in the same cycle cancel, even when the counter is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) credit_q[o] <= CW'(CREDIT_DEPTH);
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (out_gnt_any[o] && !credit_ret[o]) begin
          credit_q[o] <= credit_q[o] - 1'b1;
        end else if (!out_gnt_any[o] && credit_ret[o] && (credit_q[o] < CW'(CREDIT_DEPTH))) begin
          credit_q[o] <= credit_q[o] + 1'b1;
        end
      end
    end
  end
`else
  // A zero-depth downstream buffer could never accept a flit.
  assign credit_ok = {NUM_PORTS{CREDIT_DEPTH > 0}};
`endif

  assign in_gnt         = gnt_q;
  assign proc_sel_code  = sel_q[P_IDX];
  assign east_sel_code  = sel_q[E_IDX];
  assign south_sel_code = sel_q[S_IDX];
  assign west_sel_code  = sel_q[W_IDX];
  assign north_sel_code = sel_q[N_IDX];
  assign out_busy       = lock_q;

endmodule
